// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock.
// A single full-subtractor cell processes one bit per cycle. Its borrow is
// registered and fed back as the borrow-in of the next bit.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // The counter is kept at least 1 bit wide so that WIDTH == 1 still elaborates.
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             x, y, d, br_nx;
  logic [WIDTH-1:0] res_sh;

`ifdef SERIAL_SUB_OVF_EN
  logic amsb_q, amsb_d;
  logic bmsb_q, bmsb_d;
  logic ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs, plus the result with d shifted in at the MSB.
  always_comb begin
    x      = a_sr_q[0];
    y      = b_sr_q[0];
    d      = x ^ y ^ br_q;
    br_nx  = (~x & y) | (~(x ^ y) & br_q);
    res_sh = res_q >> 1;
    res_sh[WIDTH-1] = d;
  end

  // Next-state logic for the FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: load on an accepted start, shift in RUN, publish the result on the last bit.
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d = a;
          b_sr_d = b;
          br_d   = bin;
          cnt_d  = '0;
          res_d  = '0;
`ifdef SERIAL_SUB_OVF_EN
          amsb_d = a[WIDTH-1];
          bmsb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = res_sh;
        br_d   = br_nx;
        if (cnt_q == LAST) begin
          diff_d   = res_sh;
          borrow_d = br_nx;
`ifdef SERIAL_SUB_OVF_EN
          // d is the MSB of the finished difference on this cycle.
          ovf_d    = (amsb_q ^ bmsb_q) & (amsb_q ^ d);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers. Reset is synchronous and takes priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench driving a WIDTH=8 and a WIDTH=1 instance.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       br;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy8, done8, borrow8, busy1, done1, borrow1;
  logic [7:0] diff8;
  logic [0:0] diff1;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf1;
`endif

  int   nchk = 0, nerr = 0, cyc = 0;
  exp_t q8[$], q1[$];
  exp_t e8, e1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard side: compare each done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) check("d8_spurious_done", 1, 0);
      else begin
        e8 = q8.pop_front();
        check("d8_diff", diff8, e8.diff);
        check("d8_borrow", borrow8, e8.br);
        check("d8_latency", cyc, e8.cyc);
        check("d8_busy_at_done", busy8, 1);
`ifdef SERIAL_SUB_OVF_EN
        check("d8_ovf", ovf8, e8.ovf);
`endif
      end
    end
    if (!rst && done1) begin
      if (q1.size() == 0) check("d1_spurious_done", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("d1_diff", diff1, e1.diff);
        check("d1_borrow", borrow1, e1.br);
        check("d1_latency", cyc, e1.cyc);
      end
    end
  end

  // Drive one start on the WIDTH=8 instance and push the expected result from integer arithmetic.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bi, output int sc);
    exp_t e;
    int   full;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    sc = cyc;
    full   = int'(a) - int'(b) - int'(bi);
    e.diff = full[7:0];
    e.br   = (full < 0);
    e.ovf  = (a[7] != b[7]) && (e.diff[7] != a[7]);
    e.cyc  = sc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; bin8 = ~bi;  // later input changes must not matter
  endtask

  // Wait (bounded) for busy to fall and check that it falls on schedule.
  task automatic wait_idle8(input int sc);
    int n = 0;
    while (busy8 && n < 40) begin @(negedge clk); n++; end
    if (busy8) check("d8_busy_timeout", 1, 0);
    else check("d8_busy_fall_cycle", cyc, sc + 1 + 8 + 1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int sc;
    launch8(a, b, bi, sc);
    wait_idle8(sc);
  endtask

  task automatic op1(input logic a, input logic b, input logic bi, input logic [1:0] bd);
    exp_t e;
    int   sc, n;
    @(negedge clk);
    a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
    sc = cyc;
    e.diff = {7'd0, bd[0]};
    e.br   = bd[1];
    e.ovf  = 1'b0;
    e.cyc  = sc + 1 + 1;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (busy1 && n < 20) begin @(negedge clk); n++; end
    if (busy1) check("d1_busy_timeout", 1, 0);
    else check("d1_busy_fall_cycle", cyc, sc + 1 + 1 + 1);
  endtask

  initial begin
    logic [15:0] tt;
    int          sc;
    tt = {2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00};

    repeat (3) @(negedge clk);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_diff8", diff8, 0);
    check("rst_borrow8", borrow8, 0);
    check("rst_busy1", busy1, 0);
    rst = 1'b0;

    op8(8'h05, 8'h03, 1'b0);
    op8(8'h03, 8'h05, 1'b0);
    op8(8'h00, 8'h00, 1'b1);
    op8(8'hFF, 8'hFF, 1'b1);
    op8(8'hA5, 8'h3C, 1'b0);
    op8(8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0], tt[i*2 +: 2]);
    end

    // start during RUN is ignored: nothing is pushed for it
    launch8(8'h40, 8'h11, 1'b0, sc);
    @(negedge clk);
    a8 = 8'h01; b8 = 8'hF0; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8(sc);
    @(negedge clk);
    check("ign_stays_idle", busy8, 0);

    // leave a non-zero result behind, then reset in the 4th RUN cycle
    op8(8'h00, 8'h00, 1'b1);
    launch8(8'h77, 8'h22, 1'b0, sc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q8.delete();
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_done", done8, 0);
    check("mid_rst_diff", diff8, 0);
    check("mid_rst_borrow", borrow8, 0);
    repeat (12) @(negedge clk);
    check("post_rst_idle", busy8, 0);
    op8(8'h30, 8'h31, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    op8(8'h80, 8'h01, 1'b0);
    op8(8'h10, 8'h01, 1'b0);
    op8(8'h7F, 8'hFF, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
